// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Shared definitions for the memory port arbiter and its lane-alignment
// helper.
//
// Contents:
//   arbState_e    - arbiter FSM states (IDLE, GRANT_I, GRANT_D, ACK)
//   F3_*          - funct3 access-size codes used by loads/stores
//   BE_WORD       - byte-enable pattern for a full 32-bit word
//   accessSize_e  - decoded access width
//   decodeSize()  - maps a funct3 code onto an access width; any code that
//                   is not a byte or halfword access is handled as a word
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // Arbiter states.  GRANT_I/GRANT_D hold the memory request for the
    // fetch or data port.  ACK is the single completion cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10,
        ACK     = 2'b11
    } arbState_e;

    // funct3 encodings for the load/store width field
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // All four byte lanes enabled
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Access width after decoding funct3
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } accessSize_e;

    // Signed and unsigned variants share a width.  The reserved codes
    // (011, 110, 111) fall through to a word access so that they still
    // produce a well-defined memory transaction.
    function automatic accessSize_e decodeSize(input logic [2:0] funct3);
        accessSize_e size;
        case (funct3)
            F3_B, F3_BU: size = SIZE_BYTE;
            F3_H, F3_HU: size = SIZE_HALF;
            F3_W:        size = SIZE_WORD;
            default:     size = SIZE_WORD;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
//
// Purely combinational helper.  It turns a request's access width and
// low address bits into the byte enables, lane-replicated write data and
// an alignment-error flag for the shared memory.
//
// Ports:
//   funct3        in   3  access width code of the data request
//   addrLow       in   2  byte offset within the word (addr[1:0])
//   wdata         in  32  store data, meaningful value in the low lanes
//   isFetch       in   1  1 = instruction fetch (always a word read)
//   be            out  4  byte enables for the memory
//   alignedWdata  out 32  write data replicated into every candidate lane
//   misaligned    out  1  access crosses its natural alignment boundary
// ---------------------------------------------------------------------------
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLow,
    input  logic [31:0] wdata,
    input  logic        isFetch,
    output logic [3:0]  be,
    output logic [31:0] alignedWdata,
    output logic        misaligned
);

    // Build the lane controls for the selected request.
    // Store data is replicated across every lane rather than shifted into
    // the target lane.  The byte enables pick the lane that actually gets
    // written, which keeps the data path free of a barrel shifter.
    // Fetches are always word reads: there is no write data, and any
    // non-zero offset is reported as an alignment error.
    always_comb begin
        be           = BE_WORD;
        alignedWdata = wdata;
        misaligned   = 1'b0;

        if (isFetch) begin
            be           = BE_WORD;
            alignedWdata = '0;
            misaligned   = (addrLow != 2'b00);
        end else begin
            case (decodeSize(funct3))
                SIZE_BYTE: begin
                    be           = 4'b0001 << addrLow;
                    alignedWdata = {4{wdata[7:0]}};
                    misaligned   = 1'b0;
                end
                SIZE_HALF: begin
                    be           = 4'b0011 << {addrLow[1], 1'b0};
                    alignedWdata = {2{wdata[15:0]}};
                    misaligned   = addrLow[0];
                end
                default: begin
                    be           = BE_WORD;
                    alignedWdata = wdata;
                    misaligned   = (addrLow != 2'b00);
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Lets the instruction-fetch port and the data (MEM-stage) port share one
// single-port memory.  Each pending request gets exactly one memory
// transaction.  The data port normally has priority, but the two ports
// alternate whenever both are waiting, so neither port can starve.
// Misaligned requests and memory timeouts complete with bus_err raised.
//
// Parameters:
//   TIMEOUT    cycles a grant may wait for mem_ready before aborting (1..255)
//
// Ports:
//   clk, reset                clock, synchronous active-high reset
//   if_req/if_addr            fetch request, held until if_ack
//   if_rdata/if_ack           fetched word plus one-cycle completion pulse
//   d_req/d_we/d_addr         data request, held until d_ack
//   d_wdata/d_funct3          store data (low lanes) and access width
//   d_rdata/d_ack             raw memory word plus one-cycle completion pulse
//   mem_req/mem_we/mem_addr   memory request, held for the whole grant
//   mem_wdata/mem_be          lane-replicated write data and byte enables
//   mem_rdata/mem_ready       memory read data and completion strobe
//   bus_err                   error pulse, coincident with the ack
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_funct3,
    output logic [31:0] d_rdata,
    output logic        d_ack,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,

    output logic        bus_err
);

    // Value the wait counter holds during the last permitted grant cycle
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    arbState_e   state;
    arbState_e   nextState;

    logic [7:0]  waitCount;
    logic        lastGrantD;
    logic        prevWasAck;
    logic        errFlag;
    logic [31:0] rdataReg;

    logic        memWeReg;
    logic [31:0] memAddrReg;
    logic [31:0] memWdataReg;
    logic [3:0]  memBeReg;

    logic        maskI;
    logic        maskD;
    logic        reqI;
    logic        reqD;
    logic        pickI;
    logic        pickD;
    logic [31:0] selAddr;
    logic        timeoutHit;

    logic [3:0]  alignBe;
    logic [31:0] alignWdata;
    logic        alignMis;

    // Lane alignment for whichever port wins arbitration this cycle.
    // Its outputs are only captured in IDLE, when a grant is made.
    mem_lane_align uLaneAlign (
        .funct3       (d_funct3),
        .addrLow      (selAddr[1:0]),
        .wdata        (d_wdata),
        .isFetch      (pickI),
        .be           (alignBe),
        .alignedWdata (alignWdata),
        .misaligned   (alignMis)
    );

    // Arbitration.
    // A requester only sees its ack at the end of the ACK cycle, so it may
    // still be holding req high in the IDLE cycle that follows.  That stale
    // req must not start a second transaction.  The port acked last is the
    // one recorded in lastGrantD, so we mask that port in the single IDLE
    // cycle right after ACK.
    // When both ports are pending, the port that was not granted last time
    // wins.  This alternates D, I, D, I ... and keeps either side from
    // starving the other.
    always_comb begin
        maskI   = prevWasAck && !lastGrantD;
        maskD   = prevWasAck && lastGrantD;
        reqI    = if_req && !maskI;
        reqD    = d_req && !maskD;
        pickD   = reqD && (!reqI || !lastGrantD);
        pickI   = reqI && !pickD;
        selAddr = pickD ? d_addr : if_addr;
    end

    // The counter starts at zero in the first grant cycle, so it matches
    // TIMEOUT_LAST in the TIMEOUT-th cycle.  That limits mem_req to at most
    // TIMEOUT cycles.
    assign timeoutHit = (waitCount == TIMEOUT_LAST);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // FSM next-state logic.
    // A misaligned request never reaches the memory: it goes straight from
    // IDLE to ACK and reports the error there.  In a grant state a real
    // completion takes precedence over a timeout that lands on the same
    // cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (pickD || pickI) begin
                    if (alignMis) begin
                        nextState = ACK;
                    end else if (pickD) begin
                        nextState = GRANT_D;
                    end else begin
                        nextState = GRANT_I;
                    end
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ready || timeoutHit) begin
                    nextState = ACK;
                end
            end
            ACK: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // FSM outputs.
    // mem_req is high only in the grant states, so any mem_ready seen in
    // another state is simply ignored.  The ack is steered by lastGrantD,
    // which always names the port of the transaction being completed,
    // including the misaligned case that never entered a grant state.
    always_comb begin
        mem_req = 1'b0;
        if_ack  = 1'b0;
        d_ack   = 1'b0;
        bus_err = 1'b0;
        case (state)
            GRANT_I, GRANT_D: begin
                mem_req = 1'b1;
            end
            ACK: begin
                if_ack  = !lastGrantD;
                d_ack   = lastGrantD;
                bus_err = errFlag;
            end
            default: begin
            end
        endcase
    end

    // Transaction latch and wait counter.
    // The address, write data and byte enables are captured when the grant
    // is made, and the mem_* outputs come straight from these registers.
    // The memory therefore sees stable values for the whole grant, even if
    // a requester breaks protocol and drops its request early.
    // Read data is cleared at grant time.  It is loaded only on a genuine
    // completion, so error completions return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCount   <= '0;
            lastGrantD  <= 1'b0;
            prevWasAck  <= 1'b0;
            errFlag     <= 1'b0;
            rdataReg    <= '0;
            memWeReg    <= 1'b0;
            memAddrReg  <= '0;
            memWdataReg <= '0;
            memBeReg    <= '0;
        end else begin
            prevWasAck <= (state == ACK);
            case (state)
                IDLE: begin
                    waitCount <= '0;
                    if (pickD || pickI) begin
                        lastGrantD  <= pickD;
                        memAddrReg  <= {selAddr[31:2], 2'b00};
                        memWeReg    <= pickD && d_we && !alignMis;
                        memWdataReg <= alignWdata;
                        memBeReg    <= alignBe;
                        errFlag     <= alignMis;
                        rdataReg    <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    waitCount <= waitCount + 8'd1;
                    if (mem_ready) begin
                        rdataReg <= mem_rdata;
                        errFlag  <= 1'b0;
                    end else if (timeoutHit) begin
                        rdataReg <= '0;
                        errFlag  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Both ports read the same latched word.  Each value is only meaningful
    // while that port's ack is high.
    assign if_rdata  = rdataReg;
    assign d_rdata   = rdataReg;

    assign mem_we    = memWeReg;
    assign mem_addr  = memAddrReg;
    assign mem_wdata = memWdataReg;
    assign mem_be    = memBeReg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter.  A behavioural memory answers
// grants after a programmable delay.  A shadow memory, updated at byte
// granularity from the store rules, predicts load results.  Expected lane
// controls, latencies and grant order are derived from the access rules
// with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 4;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_err;

    int          compareCount = 0;
    int          failCount = 0;

    // Memory responder controls and observations
    int          respDelay = 1;
    int          reqCycles = 0;
    int          memReqTotal = 0;
    logic [31:0] capAddr;
    logic [31:0] capWdata;
    logic [3:0]  capBe;
    logic        capWe;
    logic [31:0] memArray [256];
    logic [31:0] shadowMem [256];

    // Per-transaction observations
    bit          gotAck;
    bit          ackAgain;
    bit          otherAck;
    int          obsLat;
    logic [31:0] obsRdata;
    logic        obsErr;
    bit          modelLastD;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_funct3  (d_funct3),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_err   (bus_err)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bound on total run time
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

    // Behavioural memory.  It answers respDelay cycles after mem_req rises
    // (0 = never answer).  Between answers it drives random read data.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                reqCycles++;
                memReqTotal++;
                if (reqCycles == 1) begin
                    capAddr  = mem_addr;
                    capWdata = mem_wdata;
                    capBe    = mem_be;
                    capWe    = mem_we;
                end
                if (respDelay != 0 && reqCycles == respDelay + 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = memArray[mem_addr[9:2]];
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++) begin
                            if (mem_be[b]) memArray[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                        end
                    end
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                reqCycles = 0;
                mem_ready = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference lane rules: width in bytes, enables covering that width at
    // the byte offset, and the low store bytes repeated across the word.
    function automatic void refLane(input bit isFetch, input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] wd, output int size, output logic [3:0] be,
                                    output logic [31:0] wdOut, output bit mis);
        int a;
        a = int'(addr[1:0]);
        if (isFetch) size = 4;
        else if (f3 == 3'b000 || f3 == 3'b100) size = 1;
        else if (f3 == 3'b001 || f3 == 3'b101) size = 2;
        else size = 4;
        mis = (a % size) != 0;
        be = 4'(((1 << size) - 1) << a);
        wdOut = '0;
        for (int i = 0; i < 4; i++) wdOut[8*i +: 8] = wd[8*(i % size) +: 8];
    endfunction

    // Issues one request on one port and records what comes back
    task automatic applyStimulus(input bit isData, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [2:0] f3, input int delay);
        int n;
        respDelay   = delay;
        memReqTotal = 0;
        gotAck = 0; ackAgain = 0; otherAck = 0; obsLat = 0; obsRdata = '0; obsErr = 1'b0;
        @(negedge clk);
        if (isData) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; d_funct3 = f3;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        n = 0;
        while (!gotAck && n < 40) begin
            @(negedge clk);
            n++;
            if (isData ? if_ack : d_ack) otherAck = 1;
            if (isData ? d_ack : if_ack) begin
                gotAck   = 1;
                obsLat   = n;
                obsRdata = isData ? d_rdata : if_rdata;
                obsErr   = bus_err;
            end
        end
        d_req  = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        if (d_ack || if_ack) ackAgain = 1;
    endtask

    task automatic runAndCheck(input string tag, input bit isData, input bit we, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [2:0] f3, input int delay);
        int          size;
        int          byteAddr;
        int          expReq;
        int          expLat;
        logic [3:0]  expBe;
        logic [31:0] expWd;
        logic [31:0] expRdata;
        bit          mis;
        refLane(!isData, f3, addr, wd, size, expBe, expWd, mis);
        expRdata = shadowMem[addr[9:2]];
        applyStimulus(isData, we, addr, wd, f3, delay);
        modelLastD = isData;
        expReq = mis ? 0 : ((delay == 0) ? TIMEOUT : delay + 1);
        expLat = mis ? 1 : expReq + 1;
        checkOutput({tag, ".ack"}, 32'(gotAck), 32'd1);
        checkOutput({tag, ".latency"}, 32'(obsLat), 32'(expLat));
        checkOutput({tag, ".busErr"}, 32'(obsErr), 32'(mis || delay == 0));
        checkOutput({tag, ".memReqCycles"}, 32'(memReqTotal), 32'(expReq));
        checkOutput({tag, ".singlePulse"}, 32'(ackAgain), 32'd0);
        checkOutput({tag, ".otherAck"}, 32'(otherAck), 32'd0);
        if (mis || delay == 0) checkOutput({tag, ".rdataZero"}, obsRdata, 32'd0);
        else if (!(isData && we)) checkOutput({tag, ".rdata"}, obsRdata, expRdata);
        if (!mis) begin
            checkOutput({tag, ".memAddr"}, capAddr, {addr[31:2], 2'b00});
            checkOutput({tag, ".memWe"}, 32'(capWe), 32'(isData && we));
            checkOutput({tag, ".memBe"}, 32'(capBe), 32'(expBe));
            if (isData && we) checkOutput({tag, ".memWdata"}, capWdata, expWd);
        end
        if (isData && we && !mis && delay != 0) begin
            for (int i = 0; i < size; i++) begin
                byteAddr = int'(addr[9:0]) + i;
                shadowMem[byteAddr / 4][8*(byteAddr % 4) +: 8] = wd[8*i +: 8];
            end
        end
    endtask

    initial begin
        logic [31:0] rAddr;
        logic [31:0] rWd;
        logic [2:0]  rF3;
        bit          rData;
        bit          rWe;
        int          rDelay;
        bit          expOrder[$];
        bit          obsOrder[$];
        int          remD;
        int          remI;
        bit          last;
        bit          pick;
        int          dCnt;
        int          iCnt;
        int          n;
        bit          seenAck;
        logic [31:0] v;

        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            memArray[i]  = v;
            shadowMem[i] = v;
        end
        memArray[64]  = 32'h0050_0093;
        shadowMem[64] = 32'h0050_0093;

        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_funct3 = '0;
        modelLastD = 0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("reset.memReq", 32'(mem_req), 32'd0);
        checkOutput("reset.memWe", 32'(mem_we), 32'd0);
        checkOutput("reset.memAddr", mem_addr, 32'd0);
        checkOutput("reset.memWdata", mem_wdata, 32'd0);
        checkOutput("reset.memBe", 32'(mem_be), 32'd0);
        checkOutput("reset.ifAck", 32'(if_ack), 32'd0);
        checkOutput("reset.dAck", 32'(d_ack), 32'd0);
        checkOutput("reset.busErr", 32'(bus_err), 32'd0);
        checkOutput("reset.ifRdata", if_rdata, 32'd0);
        checkOutput("reset.dRdata", d_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        runAndCheck("fetch", 0, 0, 32'h0000_0100, 32'h0, 3'b010, 2);
        checkOutput("fetch.rdataConst", obsRdata, 32'h0050_0093);
        runAndCheck("sb", 1, 1, 32'h0000_0203, 32'h0000_00AB, 3'b000, 1);
        checkOutput("sb.beConst", 32'(capBe), 32'h8);
        checkOutput("sb.wdataConst", capWdata, 32'hABAB_ABAB);
        runAndCheck("lwAfterSb", 1, 0, 32'h0000_0200, 32'h0, 3'b010, 3);
        runAndCheck("shUpper", 1, 1, 32'h0000_0222, 32'h0000_BEEF, 3'b001, 1);
        runAndCheck("lhuUpper", 1, 0, 32'h0000_0222, 32'h0, 3'b101, 2);
        runAndCheck("swMisaligned", 1, 1, 32'h0000_0102, 32'h1234_5678, 3'b010, 1);
        runAndCheck("lhMisaligned", 1, 0, 32'h0000_0105, 32'h0, 3'b001, 1);
        runAndCheck("fetchMisaligned", 0, 0, 32'h0000_0102, 32'h0, 3'b010, 1);
        runAndCheck("reservedF3", 1, 1, 32'h0000_0300, 32'hCAFE_F00D, 3'b111, 1);
        runAndCheck("timeout", 1, 0, 32'h0000_0010, 32'h0, 3'b010, 0);
        runAndCheck("afterTimeout", 0, 0, 32'h0000_0020, 32'h0, 3'b010, 1);

        // Reset in the middle of a data grant
        respDelay = 3;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300; d_funct3 = 3'b010;
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rstMid.grantReached", 32'(mem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstMid.memReqCleared", 32'(mem_req), 32'd0);
        checkOutput("rstMid.noAck", 32'(d_ack), 32'd0);
        reset = 1'b0;
        d_req = 1'b0;
        seenAck = 0;
        repeat (4) begin
            @(negedge clk);
            if (d_ack || if_ack || mem_req) seenAck = 1;
        end
        checkOutput("rstMid.quietAfter", 32'(seenAck), 32'd0);
        modelLastD = 0;
        runAndCheck("rstMid.fetch", 0, 0, 32'h0000_0100, 32'h0, 3'b010, 1);

        // Both ports held for three transactions each
        remD = 3; remI = 3; last = modelLastD;
        while (remD > 0 || remI > 0) begin
            if (remD > 0 && remI > 0) pick = !last;
            else pick = (remD > 0);
            expOrder.push_back(pick);
            last = pick;
            if (pick) remD--; else remI--;
        end
        respDelay = $urandom_range(1, 3);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040; d_funct3 = 3'b010;
        if_req = 1'b1; if_addr = 32'h0000_0080;
        dCnt = 0; iCnt = 0; n = 0;
        while ((dCnt < 3 || iCnt < 3) && n < 100) begin
            @(negedge clk);
            n++;
            if (d_ack) begin
                obsOrder.push_back(1'b1);
                dCnt++;
                if (dCnt == 3) d_req = 1'b0;
            end
            if (if_ack) begin
                obsOrder.push_back(1'b0);
                iCnt++;
                if (iCnt == 3) if_req = 1'b0;
            end
        end
        d_req = 1'b0;
        if_req = 1'b0;
        checkOutput("arb.count", 32'(obsOrder.size()), 32'(expOrder.size()));
        for (int k = 0; k < expOrder.size(); k++) begin
            checkOutput($sformatf("arb.order%0d", k),
                        (k < obsOrder.size()) ? 32'(obsOrder[k]) : 32'hFFFF_FFFF, 32'(expOrder[k]));
        end
        modelLastD = last;
        @(negedge clk);

        // Randomised single-port traffic
        for (int k = 0; k < 60; k++) begin
            rData  = ($urandom_range(0, 1) == 1);
            rWe    = ($urandom_range(0, 1) == 1);
            rF3    = 3'($urandom_range(0, 7));
            rAddr  = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) rAddr[1:0] = 2'b00;
            rWd    = $urandom;
            rDelay = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
            runAndCheck($sformatf("rnd%0d", k), rData, rWe, rAddr, rWd, rF3, rDelay);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
